// File: rtl/tmp101_temp_formatter_pkg.sv
// Shared definitions for the TMP101 read path: formatter FSM state encoding,
// sensor resolution constants and the fractional-tenths helper.
package tmp101_temp_formatter_pkg;

    // TMP101 in 12-bit mode: 8 integer bits, 4 fraction bits (1/16 degree C).
    localparam int TEMP_WIDTH = 12;
    localparam int FRAC_BITS  = 4;
    localparam int INT_BITS   = TEMP_WIDTH - FRAC_BITS;

    // Formatter FSM encoding, kept as plain constants for legacy tools.
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_LSB = 2'd1;
    localparam logic [1:0] ST_CONVERT  = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    // Truncated tenths digit of a sixteenths fraction: (frac * 10) >> 4.
    function automatic logic [3:0] tenths_of(input logic [FRAC_BITS-1:0] frac);
        logic [7:0] prod;
        prod = {4'd0, frac} * 8'd10;
        return prod[7:4];
    endfunction

endpackage

// File: rtl/tmp101_temp_formatter_bin2bcd8.sv
// Sequential double-dabble: converts an 8-bit binary value to three BCD
// digits, one bit per cycle. A start pulse loads the operand; done is high
// for exactly one cycle after the eighth shift.
module Bin2BCD8
    import tmp101_temp_formatter_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [INT_BITS-1:0] bin,
    output logic                done,
    output logic [3:0]          hundreds,
    output logic [3:0]          tens,
    output logic [3:0]          ones
);

    logic [7:0] shreg;
    logic [3:0] cnt;
    logic       active;
    logic [3:0] h_r, t_r, o_r;
    logic [3:0] h_adj, t_adj, o_adj;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Add-3 correction applied to every digit ahead of each shift.
    always_comb begin
        h_adj = add3(h_r);
        t_adj = add3(t_r);
        o_adj = add3(o_r);
    end

    // Load on start, then shift one binary bit into the BCD digits per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg  <= '0;
            cnt    <= '0;
            active <= 1'b0;
            h_r    <= '0;
            t_r    <= '0;
            o_r    <= '0;
        end else if (start) begin
            shreg  <= bin;
            cnt    <= '0;
            active <= 1'b1;
            h_r    <= '0;
            t_r    <= '0;
            o_r    <= '0;
        end else if (active) begin
            if (cnt == 4'd8) begin
                active <= 1'b0;
            end else begin
                {h_r, t_r, o_r, shreg} <= {h_adj, t_adj, o_adj, shreg} << 1;
                cnt <= cnt + 4'd1;
            end
        end
    end

    assign done     = active && (cnt == 4'd8);
    assign hundreds = h_r;
    assign tens     = t_r;
    assign ones     = o_r;

endmodule

// File: rtl/tmp101_temp_formatter.sv
// Collects the MSB/LSB bytes of a TMP101 temperature read, converts the
// reading to sign + BCD magnitude (tenths truncated) and presents it with a
// one-cycle DataValid. Timeouts and stray bytes pulse FrameError; FrameStart
// silently aborts any frame in progress. State is exposed on State for debug.
module tmp101_temp_formatter
    import tmp101_temp_formatter_pkg::*;
#(
    parameter logic [19:0] TimeoutCycles = 20'd600000
) (
    input  logic                  clock,
    input  logic                  Reset,
    input  logic                  FrameStart,
    input  logic                  ByteValid,
    input  logic [7:0]            ReceivedData,
    output logic [TEMP_WIDTH-1:0] Temperature,
    output logic                  Sign,
    output logic [3:0]            Hundreds,
    output logic [3:0]            Tens,
    output logic [3:0]            Ones,
    output logic [3:0]            Tenths,
    output logic                  DataValid,
    output logic                  Busy,
    output logic                  FrameError,
    output logic [1:0]            State
);

    localparam logic [19:0] TIMEOUT_LAST = TimeoutCycles - 20'd1;

    logic [1:0]            state;
    logic [7:0]            msb_r;
    logic [19:0]           cnt;
    logic [TEMP_WIDTH-1:0] pend_temp;
    logic [3:0]            pend_tenths;

    logic [TEMP_WIDTH-1:0] new_temp;
    logic [TEMP_WIDTH:0]   mag;
    logic                  cvt_start;
    logic                  cvt_done;
    logic [3:0]            cvt_h, cvt_t, cvt_o;
    logic                  unused_bits;

    // Assemble the reading from the held MSB and the arriving LSB; the
    // magnitude is one bit wider so that -128.0 (0x800) negates cleanly.
    always_comb begin
        new_temp = {msb_r, ReceivedData[7:4]};
        if (new_temp[TEMP_WIDTH-1])
            mag = '0 - {new_temp[TEMP_WIDTH-1], new_temp};
        else
            mag = {1'b0, new_temp};
    end

    // Low LSB nibble carries no data in 12-bit mode; mag[12] is always zero.
    assign unused_bits = ^{mag[TEMP_WIDTH], ReceivedData[3:0]};

    // Kick the converter in the same cycle the LSB is accepted.
    assign cvt_start = (state == ST_WAIT_LSB) && ByteValid && !FrameStart;

    Bin2BCD8 u_bin2bcd (
        .clk      (clock),
        .rst_n    (Reset),
        .start    (cvt_start),
        .bin      (mag[TEMP_WIDTH-1:FRAC_BITS]),
        .done     (cvt_done),
        .hundreds (cvt_h),
        .tens     (cvt_t),
        .ones     (cvt_o)
    );

    // Frame FSM, byte capture, timeout counter and output registers.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state       <= ST_IDLE;
            msb_r       <= '0;
            cnt         <= '0;
            pend_temp   <= '0;
            pend_tenths <= '0;
            Temperature <= '0;
            Sign        <= 1'b0;
            Hundreds    <= '0;
            Tens        <= '0;
            Ones        <= '0;
            Tenths      <= '0;
            DataValid   <= 1'b0;
            FrameError  <= 1'b0;
        end else begin
            DataValid  <= 1'b0;
            FrameError <= 1'b0;
            if (FrameStart) begin
                // A byte arriving with FrameStart is the MSB of the new frame.
                if (ByteValid) begin
                    msb_r <= ReceivedData;
                    cnt   <= '0;
                    state <= ST_WAIT_LSB;
                end else begin
                    state <= ST_IDLE;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ByteValid) begin
                            msb_r <= ReceivedData;
                            cnt   <= '0;
                            state <= ST_WAIT_LSB;
                        end
                    end
                    ST_WAIT_LSB: begin
                        if (ByteValid) begin
                            pend_temp   <= new_temp;
                            pend_tenths <= tenths_of(mag[FRAC_BITS-1:0]);
                            state       <= ST_CONVERT;
                        end else if (cnt == TIMEOUT_LAST) begin
                            FrameError <= 1'b1;
                            state      <= ST_IDLE;
                        end else begin
                            cnt <= cnt + 20'd1;
                        end
                    end
                    ST_CONVERT: begin
                        if (ByteValid)
                            FrameError <= 1'b1;
                        if (cvt_done) begin
                            Temperature <= pend_temp;
                            Sign        <= pend_temp[TEMP_WIDTH-1];
                            Hundreds    <= cvt_h;
                            Tens        <= cvt_t;
                            Ones        <= cvt_o;
                            Tenths      <= pend_tenths;
                            DataValid   <= 1'b1;
                            state       <= ST_DONE;
                        end
                    end
                    default: begin
                        if (ByteValid)
                            FrameError <= 1'b1;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign Busy  = (state == ST_WAIT_LSB) || (state == ST_CONVERT);
    assign State = state;

endmodule

// File: tb/tb_tmp101_temp_formatter.sv
// Bench for tmp101_temp_formatter: directed byte frames with hand-computed
// results, timeout, stray-byte, abort and reset-during-convert scenarios.
module tb_tmp101_temp_formatter;

    localparam int W = 29;  // {temp[11:0], sign, hundreds, tens, ones, tenths}

    logic        clock = 1'b0;
    logic        Reset = 1'b0;
    logic        FrameStart = 1'b0;
    logic        ByteValid = 1'b0;
    logic [7:0]  ReceivedData = 8'h00;
    logic [11:0] Temperature;
    logic        Sign;
    logic [3:0]  Hundreds, Tens, Ones, Tenths;
    logic        DataValid, Busy, FrameError;
    logic [1:0]  State;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [W-1:0] exp_q[$];
    int           lat_q[$];
    int           fe_q[$];
    logic [W-1:0] last_exp = '0;

    tmp101_temp_formatter #(.TimeoutCycles(20'd20)) dut (
        .clock        (clock),
        .Reset        (Reset),
        .FrameStart   (FrameStart),
        .ByteValid    (ByteValid),
        .ReceivedData (ReceivedData),
        .Temperature  (Temperature),
        .Sign         (Sign),
        .Hundreds     (Hundreds),
        .Tens         (Tens),
        .Ones         (Ones),
        .Tenths       (Tenths),
        .DataValid    (DataValid),
        .Busy         (Busy),
        .FrameError   (FrameError),
        .State        (State)
    );

    // Clock and cycle counter.
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [W-1:0] mk(input logic [11:0] t, input logic s,
                                        input logic [3:0] h, input logic [3:0] te,
                                        input logic [3:0] o, input logic [3:0] tn);
        return {t, s, h, te, o, tn};
    endfunction

    function automatic logic [W-1:0] cur_out();
        return {Temperature, Sign, Hundreds, Tens, Ones, Tenths};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected results and FrameError cycles as the DUT reports.
    always @(negedge clock) begin
        if (Reset) begin
            if (DataValid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_datavalid: got 0x%0h expected none (cycle %0d)", cur_out(), cyc);
                end else begin
                    logic [W-1:0] e;
                    int           l;
                    e = exp_q.pop_front();
                    l = lat_q.pop_front();
                    check("result", {3'd0, cur_out()}, {3'd0, e});
                    check("latency", cyc, l);
                end
            end
            if (FrameError) begin
                if (fe_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_frameerror: got pulse expected none (cycle %0d)", cyc);
                end else begin
                    check("frameerror_cycle", cyc, fe_q.pop_front());
                end
            end
        end
    end

    // Drivers: every task starts and ends 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b, input logic fs, output int k);
        ByteValid    = 1'b1;
        ReceivedData = b;
        FrameStart   = fs;
        @(posedge clock);
        #1;
        k            = cyc;
        ByteValid    = 1'b0;
        FrameStart   = 1'b0;
        ReceivedData = 8'h00;
    endtask

    task automatic pulse_fs();
        FrameStart = 1'b1;
        @(posedge clock);
        #1;
        FrameStart = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic frame(input logic [7:0] msb, input logic [7:0] lsb,
                         input logic fs, input logic [W-1:0] e);
        int k;
        send_byte(msb, fs, k);
        send_byte(lsb, 1'b0, k);
        exp_q.push_back(e);
        lat_q.push_back(k + 9);
        last_exp = e;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fe_q.size() != 0) && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (exp_q.size() != 0 || fe_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_timeout: got %0d results and %0d errors pending expected 0",
                     exp_q.size(), fe_q.size());
            exp_q.delete();
            lat_q.delete();
            fe_q.delete();
        end
        idle(2);
    endtask

    logic [7:0]  msb_t [0:7] = '{8'h19, 8'hE7, 8'h7F, 8'h80, 8'h00, 8'hFF, 8'h4B, 8'hC9};
    logic [7:0]  lsb_t [0:7] = '{8'h00, 8'h00, 8'hF0, 8'h00, 8'h80, 8'hF0, 8'h8F, 8'h40};
    logic [11:0] tmp_t [0:7] = '{12'h190, 12'hE70, 12'h7FF, 12'h800, 12'h008, 12'hFFF, 12'h4B8, 12'hC94};
    logic        sgn_t [0:7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] dig_t [0:7] = '{16'h0250, 16'h0250, 16'h1279, 16'h1280,
                                 16'h0005, 16'h0000, 16'h0755, 16'h0547};

    // Stimulus sequence.
    initial begin
        int k;
        logic [15:0] d;

        // Reset state.
        idle(3);
        check("reset_outputs", {3'd0, cur_out()}, 32'd0);
        check("reset_flags", {29'd0, DataValid, Busy, FrameError}, 32'd0);
        check("reset_state", {30'd0, State}, 32'd0);
        Reset = 1'b1;
        idle(2);

        // Directed readings.
        for (int i = 0; i < 8; i++) begin
            d = dig_t[i];
            frame(msb_t[i], lsb_t[i], 1'b0, mk(tmp_t[i], sgn_t[i], d[15:12], d[11:8], d[7:4], d[3:0]));
            wait_done(30);
            check("hold_after_frame", {3'd0, cur_out()}, {3'd0, last_exp});
        end

        // MSB only: timeout after 20 cycles, outputs held.
        send_byte(8'h55, 1'b0, k);
        check("busy_wait_lsb", {31'd0, Busy}, 32'd1);
        fe_q.push_back(k + 20);
        wait_done(40);
        check("hold_after_timeout", {3'd0, cur_out()}, {3'd0, last_exp});
        check("idle_after_timeout", {30'd0, State}, 32'd0);
        check("busy_after_timeout", {31'd0, Busy}, 32'd0);

        // Stray byte during CONVERT: FrameError, result still delivered.
        frame(8'h19, 8'h00, 1'b0, mk(12'h190, 1'b0, 4'd0, 4'd2, 4'd5, 4'd0));
        idle(2);
        send_byte(8'hAA, 1'b0, k);
        fe_q.push_back(k);
        wait_done(30);

        // FrameStart aborts WAIT_LSB: no result, no timeout afterwards.
        send_byte(8'h33, 1'b0, k);
        pulse_fs();
        idle(30);
        check("hold_after_abort_wait", {3'd0, cur_out()}, {3'd0, last_exp});

        // FrameStart aborts CONVERT: no DataValid.
        send_byte(8'h12, 1'b0, k);
        send_byte(8'h00, 1'b0, k);
        idle(2);
        pulse_fs();
        idle(15);
        check("hold_after_abort_convert", {3'd0, cur_out()}, {3'd0, last_exp});

        // Reset during CONVERT: everything zero, nothing follows.
        send_byte(8'h19, 1'b0, k);
        send_byte(8'h00, 1'b0, k);
        idle(3);
        Reset = 1'b0;
        #2;
        check("midreset_outputs", {3'd0, cur_out()}, 32'd0);
        check("midreset_flags", {29'd0, DataValid, Busy, FrameError}, 32'd0);
        idle(1);
        Reset = 1'b1;
        last_exp = '0;
        idle(15);
        check("hold_after_midreset", {3'd0, cur_out()}, 32'd0);

        // FrameStart coincident with the MSB starts a normal frame.
        frame(8'h19, 8'h00, 1'b1, mk(12'h190, 1'b0, 4'd0, 4'd2, 4'd5, 4'd0));
        wait_done(30);
        check("hold_final", {3'd0, cur_out()}, {3'd0, last_exp});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
